step_goal_countdown: RTL and testbench

- Companion to the step tracker, counting in the opposite direction.
- A 4-digit BCD step goal is loaded, and the remaining count decrements once per step in BCD.
- Goal reached: the block flags it, then counts overshoot steps upward, saturating at 9999.
- Digit outputs use the same 5-bit BCD digit format the seven-segment decoder already consumes, so the block plugs in alongside the tracker's display path.

---
 rtl/step_goal_countdown_pkg.sv | 30 +++
 rtl/step_goal_countdown_bcd_digit.sv | 40 ++++
 rtl/step_goal_countdown.sv | 126 ++++++++++++
 tb/tb_step_goal_countdown.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/step_goal_countdown_pkg.sv
// Purpose: shared types and constants for the step goal countdown block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state enum, BCD digit limits, display digit width, blank code,
//           overshoot saturation value and the goal digit clamp helper.
package step_goal_countdown_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Largest legal BCD digit; goal digits above it are clamped at load.
   localparam logic [3:0] MAX_DIGIT = 4'd9;

   // Width of one display digit as consumed by the seven-segment decoder.
   localparam int DIGIT_W = 5;

   // Blank code understood by the display path; never driven by this block.
   localparam logic [DIGIT_W-1:0] BLANK_DIGIT = 5'h1F;

   // Overshoot saturation value, four BCD digits (9999).
   localparam logic [15:0] SAT_VALUE = 16'h9999;

   function automatic logic [3:0] clamp_digit(input logic [3:0] d);
      return (d > MAX_DIGIT) ? MAX_DIGIT : d;
   endfunction

endpackage

// File: rtl/step_goal_countdown_bcd_digit.sv
// Purpose: single BCD digit register, counts up or down with carry/borrow chaining.
// Latency: one step_clk edge from enable/load to new value; cout is combinational.
// Backpressure: none; the digit moves whenever en and cin are both high.
// Ports: step_clk/reset; ld + ld_val load the digit (priority over counting);
//        en gates counting; up selects increment (1) or decrement (0);
//        cin is the carry/borrow from the lower digit; q is the digit value;
//        cout signals this digit wraps on the next counted edge.
module step_goal_countdown_bcd_digit
   import step_goal_countdown_pkg::*;
(
   input  logic       step_clk,
   input  logic       reset,
   input  logic       ld,
   input  logic [3:0] ld_val,
   input  logic       en,
   input  logic       up,
   input  logic       cin,
   output logic [3:0] q,
   output logic       cout
);

   // Carry out only depends on the current value and the incoming carry, so
   // the top-level enable may use the last digit's cout without a loop.
   assign cout = cin & (up ? (q == MAX_DIGIT) : (q == 4'd0));

   always_ff @(posedge step_clk or posedge reset) begin
      if (reset) begin
         q <= 4'd0;
      end else if (ld) begin
         q <= ld_val;
      end else if (en && cin) begin
         if (up) begin
            q <= (q == MAX_DIGIT) ? 4'd0 : q + 4'd1;
         end else begin
            q <= (q == 4'd0) ? MAX_DIGIT : q - 4'd1;
         end
      end
   end

endmodule

// File: rtl/step_goal_countdown.sv
// Purpose: BCD step goal countdown; counts remaining steps down, then overshoot up to 9999.
// Latency: one step_clk edge from step/load to updated outputs; reset acts immediately.
// Backpressure: none; every step_clk rising edge is a step unless it carries a load.
// Ports: step_clk/reset; load + goal3..goal0 load a new goal; bcd3..bcd0 are the
//        5-bit display digits; armed, goal_met, so are the status flags.
module step_goal_countdown
   import step_goal_countdown_pkg::*;
(
   input  logic               step_clk,
   input  logic               reset,
   input  logic               load,
   input  logic [3:0]         goal3,
   input  logic [3:0]         goal2,
   input  logic [3:0]         goal1,
   input  logic [3:0]         goal0,
   output logic [DIGIT_W-1:0] bcd3,
   output logic [DIGIT_W-1:0] bcd2,
   output logic [DIGIT_W-1:0] bcd1,
   output logic [DIGIT_W-1:0] bcd0,
   output logic               armed,
   output logic               goal_met,
   output logic               so
);

   state_t      state;
   logic [15:0] goal_cl;
   logic [15:0] rem;
   logic [15:0] ov;
   logic [4:0]  rem_b;
   logic [4:0]  ov_c;
   logic        rem_en;
   logic        ov_en;
   logic [15:0] disp;

   assign goal_cl = {clamp_digit(goal3), clamp_digit(goal2),
                     clamp_digit(goal1), clamp_digit(goal0)};

   // Units digit always sees a step; higher digits see the ripple.
   assign rem_b[0] = 1'b1;
   assign ov_c[0]  = 1'b1;

   // rem_b[4] would mean an underflow below 0000, ov_c[4] a wrap past 9999;
   // both freeze their bank.
   assign rem_en = (state == ARMED) & ~load & ~rem_b[4];
   assign ov_en  = (state == DONE)  & ~load & ~ov_c[4];

   for (genvar i = 0; i < 4; i++) begin : g_digit
      step_goal_countdown_bcd_digit u_rem (
         .step_clk (step_clk),
         .reset    (reset),
         .ld       (load),
         .ld_val   (goal_cl[4*i +: 4]),
         .en       (rem_en),
         .up       (1'b0),
         .cin      (rem_b[i]),
         .q        (rem[4*i +: 4]),
         .cout     (rem_b[i+1])
      );

      step_goal_countdown_bcd_digit u_ov (
         .step_clk (step_clk),
         .reset    (reset),
         .ld       (load),
         .ld_val   (4'd0),
         .en       (ov_en),
         .up       (1'b1),
         .cin      (ov_c[i]),
         .q        (ov[4*i +: 4]),
         .cout     (ov_c[i+1])
      );
   end

   always_ff @(posedge step_clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         armed    <= 1'b0;
         goal_met <= 1'b0;
         so       <= 1'b0;
      end else if (load) begin
         so <= 1'b0;
         if (goal_cl == 16'h0000) begin
            state    <= DONE;
            armed    <= 1'b0;
            goal_met <= 1'b1;
         end else begin
            state    <= ARMED;
            armed    <= 1'b1;
            goal_met <= 1'b0;
         end
      end else begin
         case (state)
            ARMED: begin
               // This edge takes remaining from 0001 to 0000.
               if (rem == 16'h0001) begin
                  state    <= DONE;
                  armed    <= 1'b0;
                  goal_met <= 1'b1;
               end
            end
            DONE: begin
               // Flag on the edge that lands the count on the saturation value.
               if (ov_en && ov[15:4] == SAT_VALUE[15:4] &&
                   ov[3:0] == SAT_VALUE[3:0] - 4'd1) begin
                  so <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      disp = 16'h0000;
      case (state)
         ARMED:   disp = rem;
         DONE:    disp = ov;
         default: disp = 16'h0000;
      endcase
   end

   assign bcd3 = {1'b0, disp[15:12]};
   assign bcd2 = {1'b0, disp[11:8]};
   assign bcd1 = {1'b0, disp[7:4]};
   assign bcd0 = {1'b0, disp[3:0]};

endmodule

// File: tb/tb_step_goal_countdown.sv
// Purpose: self-checking bench for step_goal_countdown against an integer reference model.
// Latency: outputs compared 1 time unit after each step_clk rising edge.
// Backpressure: n/a.
module tb_step_goal_countdown;

   logic       step_clk = 1'b0;
   logic       reset    = 1'b1;
   logic       load     = 1'b0;
   logic [3:0] goal3 = 4'd0, goal2 = 4'd0, goal1 = 4'd0, goal0 = 4'd0;
   logic [4:0] bcd3, bcd2, bcd1, bcd0;
   logic       armed, goal_met, so;

   step_goal_countdown dut (
      .step_clk (step_clk),
      .reset    (reset),
      .load     (load),
      .goal3    (goal3),
      .goal2    (goal2),
      .goal1    (goal1),
      .goal0    (goal0),
      .bcd3     (bcd3),
      .bcd2     (bcd2),
      .bcd1     (bcd1),
      .bcd0     (bcd0),
      .armed    (armed),
      .goal_met (goal_met),
      .so       (so)
   );

   always #5 step_clk = ~step_clk;

   int total = 0;
   int bad   = 0;

   // Reference model: mode 0 idle, 1 counting down, 2 goal met.
   int m_mode;
   int m_rem;
   int m_ov;
   bit m_so;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [15:0] to_bcd(input int v);
      logic [15:0] r;
      r[15:12] = 4'((v / 1000) % 10);
      r[11:8]  = 4'((v / 100) % 10);
      r[7:4]   = 4'((v / 10) % 10);
      r[3:0]   = 4'(v % 10);
      return r;
   endfunction

   function automatic int clampv(input logic [3:0] d);
      return (d > 4'd9) ? 9 : int'(d);
   endfunction

   function automatic logic [15:0] disp();
      return {bcd3[3:0], bcd2[3:0], bcd1[3:0], bcd0[3:0]};
   endfunction

   task automatic model_reset();
      m_mode = 0;
      m_rem  = 0;
      m_ov   = 0;
      m_so   = 1'b0;
   endtask

   task automatic model_edge(input bit ld, input logic [15:0] g);
      int gv;
      if (ld) begin
         gv = clampv(g[15:12]) * 1000 + clampv(g[11:8]) * 100 +
              clampv(g[7:4]) * 10 + clampv(g[3:0]);
         m_ov = 0;
         m_so = 1'b0;
         m_rem = gv;
         m_mode = (gv == 0) ? 2 : 1;
      end else if (m_mode == 1) begin
         m_rem--;
         if (m_rem == 0) m_mode = 2;
      end else if (m_mode == 2) begin
         if (m_ov < 9999) m_ov++;
         if (m_ov == 9999) m_so = 1'b1;
      end
   endtask

   task automatic check_outputs();
      int shown;
      shown = (m_mode == 1) ? m_rem : (m_mode == 2) ? m_ov : 0;
      check("disp",     32'(disp()), 32'(to_bcd(shown)));
      check("msbs",     32'({bcd3[4], bcd2[4], bcd1[4], bcd0[4]}), 32'd0);
      check("armed",    32'(armed), 32'(m_mode == 1));
      check("goal_met", 32'(goal_met), 32'(m_mode == 2));
      check("so",       32'(so), 32'(m_so));
   endtask

   task automatic step(input bit ld, input logic [15:0] g);
      @(negedge step_clk);
      load  = ld;
      goal3 = g[15:12];
      goal2 = g[11:8];
      goal1 = g[7:4];
      goal0 = g[3:0];
      @(posedge step_clk);
      model_edge(ld, g);
      #1;
      check_outputs();
   endtask

   initial begin
      logic [15:0] g;
      bit          ld;

      model_reset();
      #12;
      check_outputs();
      @(negedge step_clk);
      reset = 1'b0;
      // Idle edges are ignored.
      step(1'b0, 16'h0000);

      // Goal 0012 then 12 steps, then 3 overshoot steps.
      step(1'b1, 16'h0012);
      repeat (11) step(1'b0, 16'h0000);
      check("plan_step11", 32'(disp()), 32'h0001);
      step(1'b0, 16'h0000);
      check("plan_step12", 32'(disp()), 32'h0000);
      check("plan_met",    32'(goal_met), 32'd1);
      repeat (3) step(1'b0, 16'h0000);
      check("plan_over3",  32'(disp()), 32'h0003);

      // Borrow ripple.
      step(1'b1, 16'h1000);
      step(1'b0, 16'h0000);
      check("ripple_1000", 32'(disp()), 32'h0999);
      step(1'b1, 16'h0100);
      step(1'b0, 16'h0000);
      check("ripple_0100", 32'(disp()), 32'h0099);

      // Zero goal meets immediately.
      step(1'b1, 16'h0000);
      check("zero_met", 32'(goal_met), 32'd1);
      step(1'b0, 16'h0000);
      check("zero_over1", 32'(disp()), 32'h0001);

      // Illegal tens digit clamps to 9.
      step(1'b1, 16'h00C0);
      check("clamp_tens", 32'(disp()), 32'h0090);

      // Saturation.
      step(1'b1, 16'h0001);
      step(1'b0, 16'h0000);
      repeat (9999) step(1'b0, 16'h0000);
      check("sat_val", 32'(disp()), 32'h9999);
      check("sat_so",  32'(so), 32'd1);
      repeat (3) step(1'b0, 16'h0000);
      check("sat_hold", 32'(disp()), 32'h9999);
      step(1'b1, 16'h0005);
      check("sat_clear", 32'(so), 32'd0);

      // Asynchronous reset mid-count at 0457.
      step(1'b1, 16'h0458);
      step(1'b0, 16'h0000);
      check("pre_reset", 32'(disp()), 32'h0457);
      @(negedge step_clk);
      load = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      model_reset();
      check("async_disp",  32'(disp()), 32'h0000);
      check("async_flags", 32'({armed, goal_met, so}), 32'd0);
      check_outputs();
      @(negedge step_clk);
      reset = 1'b0;

      // Reload while counting down: the load edge does not decrement.
      step(1'b1, 16'h0050);
      step(1'b0, 16'h0000);
      step(1'b0, 16'h0000);
      step(1'b1, 16'h0020);
      check("reload", 32'(disp()), 32'h0020);

      // Random loads, including illegal digits and small goals.
      for (int n = 0; n < 2000; n++) begin
         ld = ($urandom_range(0, 15) == 0);
         g  = 16'($urandom);
         if ($urandom_range(0, 2) == 0) g[15:8] = 8'h00;
         if ($urandom_range(0, 4) == 0) g[7:4] = 4'h0;
         step(ld, g);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
